cfg_ram_loader: RTL

Configuration write master that drives the `addr_wr` / `sram_sel` / `wr_en` / `din` write port shared by all configuration RAM groups. It accepts framed 64-bit configuration words from the host-side stream (valid/ready, `s_last`-delimited) and decodes one header word per frame. It then issues one registered RAM write per payload word, walking entry address 0..3 within each unit before advancing to the next unit. It reports completion and errors per frame.

---
 rtl/cfg_ram_loader.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/cfg_ram_loader.sv
// cfg_ram_loader: framed host stream -> configuration RAM write port.
// One header word per frame selects the start unit/entry and the payload
// length; each payload word becomes one registered write, walking entry
// 0..3 inside a unit before moving to the next unit.
module cfg_ram_loader #(
  parameter logic [7:0] MAGIC   = 8'hC5,
  parameter logic [7:0] SEL_MAX = 8'd255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [63:0] s_data,
  input  logic        s_last,
  output logic [1:0]  addr_wr,
  output logic [7:0]  sram_sel,
  output logic        wr_en,
  output logic [63:0] din,
  output logic        done,
  output logic        err
);

  typedef enum logic [1:0] {IDLE, DATA, DRAIN, DONE} state_t;

  state_t      state_q, state_d;
  logic        rdy_q, rdy_d;
  logic        flag_q, flag_d;
  logic [1:0]  cur_addr_q, cur_addr_d;
  logic [8:0]  cur_sel_q, cur_sel_d;   // extra bit catches the 255->256 carry
  logic [9:0]  rem_q, rem_d;
  logic        wr_en_q, wr_en_d;
  logic [1:0]  addr_q, addr_d;
  logic [7:0]  sel_q, sel_d;
  logic [63:0] din_q, din_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic        xfer;
  logic        hdr_bad;

  assign xfer    = s_valid && rdy_q;
  assign hdr_bad = (s_data[63:56] != MAGIC) || ({1'b0, s_data[7:0]} > {1'b0, SEL_MAX});

  // Next-state, datapath and registered-output decode.
  always_comb begin
    state_d    = state_q;
    flag_d     = flag_q;
    cur_addr_d = cur_addr_q;
    cur_sel_d  = cur_sel_q;
    rem_d      = rem_q;
    wr_en_d    = 1'b0;
    addr_d     = addr_q;
    sel_d      = sel_q;
    din_d      = din_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    case (state_q)
      IDLE: if (xfer) begin
        if (hdr_bad || s_last) begin
          // Bad header, or a good header with no payload behind it.
          flag_d  = 1'b1;
          state_d = s_last ? DONE : DRAIN;
        end else begin
          cur_addr_d = s_data[9:8];
          cur_sel_d  = {1'b0, s_data[7:0]};
          rem_d      = s_data[25:16];
          state_d    = DATA;
        end
      end
      DATA: if (xfer) begin
        if (cur_sel_q > {1'b0, SEL_MAX}) begin
          // Target walked past the last unit: drop the word, flag the frame.
          flag_d  = 1'b1;
          state_d = s_last ? DONE : DRAIN;
        end else begin
          wr_en_d    = 1'b1;
          addr_d     = cur_addr_q;
          sel_d      = cur_sel_q[7:0];
          din_d      = s_data;
          cur_addr_d = cur_addr_q + 2'd1;
          if (cur_addr_q == 2'd3) cur_sel_d = cur_sel_q + 9'd1;
          if (rem_q == 10'd0) begin
            if (!s_last) flag_d = 1'b1;   // long frame
            state_d = s_last ? DONE : DRAIN;
          end else if (s_last) begin
            flag_d  = 1'b1;               // short frame
            state_d = DONE;
          end else begin
            rem_d = rem_q - 10'd1;
          end
        end
      end
      DRAIN: if (xfer && s_last) state_d = DONE;
      DONE: begin
        done_d  = 1'b1;
        err_d   = flag_q;
        flag_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Ready is registered so it stays low through reset and the DONE cycle.
    rdy_d = (state_d != DONE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      rdy_q      <= 1'b0;
      flag_q     <= 1'b0;
      cur_addr_q <= 2'd0;
      cur_sel_q  <= 9'd0;
      rem_q      <= 10'd0;
      wr_en_q    <= 1'b0;
      addr_q     <= 2'd0;
      sel_q      <= 8'd0;
      din_q      <= 64'd0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      rdy_q      <= rdy_d;
      flag_q     <= flag_d;
      cur_addr_q <= cur_addr_d;
      cur_sel_q  <= cur_sel_d;
      rem_q      <= rem_d;
      wr_en_q    <= wr_en_d;
      addr_q     <= addr_d;
      sel_q      <= sel_d;
      din_q      <= din_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign s_ready  = rdy_q;
  assign wr_en    = wr_en_q;
  assign addr_wr  = addr_q;
  assign sram_sel = sel_q;
  assign din      = din_q;
  assign done     = done_q;
  assign err      = err_q;

endmodule
